insn_fetch: RTL and testbench

INSN_FETCH -- requirements
Module: insn_fetch

---
 rtl/insn_fetch.sv | 149 ++++++++++++++
 tb/tb_insn_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
// Instruction fetch front end: credit-limited in-order memory requests, a response FIFO,
// and a registered output stage with stall hold and redirect flush.
package core;
    parameter int unsigned ADDR_WIDTH = 12;
    parameter int unsigned INSN_WIDTH = 32;
    parameter logic [ADDR_WIDTH-1:0] INSN_ADDR_START = 12'h100;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INSN_WIDTH-1:0] insn;
    } InsnBundle;
endpackage

module insn_fetch #(
    parameter int unsigned ADDR_WIDTH = core::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] INSN_ADDR_START = core::INSN_ADDR_START,
    parameter int unsigned INSN_WIDTH = core::INSN_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] mem_rsp_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output core::InsnBundle       stage_out_insn
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef logic [CntW-1:0] cnt_t;

    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t                  outstanding_q, outstanding_d;
    cnt_t                  drop_cnt_q, drop_cnt_d;
    cnt_t                  count_q, count_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    core::InsnBundle       out_q, out_d;

    logic [ADDR_WIDTH+INSN_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [CntW:0] credit_used;
    logic          req_fire;
    logic          dropping;
    logic          push;
    logic          pop;

    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
    assign credit_used   = {1'b0, outstanding_q} + {1'b0, count_q};
    assign mem_req_valid = !rst && !redirect_valid && (credit_used < (CntW + 1)'(FIFO_DEPTH));
    assign mem_req_addr  = req_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign dropping      = (drop_cnt_q != '0);
    assign push          = mem_rsp_valid && !dropping && !redirect_valid;
    assign pop           = !redirect_valid && !stall && (count_q != '0);

    assign stage_out_insn = out_q;

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_d         = out_q;

        if (req_fire) begin
            req_pc_d = req_pc_q + ADDR_WIDTH'(1);
        end

        case ({req_fire, mem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + cnt_t'(1);
            2'b01:   outstanding_d = outstanding_q - cnt_t'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (mem_rsp_valid && dropping) begin
            drop_cnt_d = drop_cnt_q - cnt_t'(1);
        end

        if (push) begin
            rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(1);
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // No bypass: an empty FIFO yields valid=0 even if a push lands this cycle.
        if (pop) begin
            rd_ptr_d                = rd_ptr_q + PtrW'(1);
            out_d.valid             = 1'b1;
            {out_d.addr, out_d.insn} = fifo_mem[rd_ptr_q];
        end else if (!stall) begin
            out_d.valid = 1'b0;
        end

        // Responses still in flight (minus one landing now) belong to the old stream.
        if (redirect_valid) begin
            req_pc_d    = redirect_addr;
            rsp_pc_d    = redirect_addr;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_d.valid = 1'b0;
            drop_cnt_d  = mem_rsp_valid ? outstanding_q - cnt_t'(1) : outstanding_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q      <= INSN_ADDR_START;
            rsp_pc_q      <= INSN_ADDR_START;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_q         <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_q         <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {rsp_pc_q, mem_rsp_data};
        end
    end
endmodule

// File: tb/tb_insn_fetch.sv
// Scoreboard bench for insn_fetch: a fixed-latency in-order memory model feeds the DUT and a
// monitor compares every presented instruction against an expected-address queue.
module tb_insn_fetch;
    localparam int unsigned AW = 12;
    localparam int unsigned IW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_req_ready = 1'b1;
    logic            stall = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [AW-1:0]   redirect_addr = '0;
    logic            mem_req_valid;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_rsp_valid;
    logic [IW-1:0]   mem_rsp_data;
    core::InsnBundle out;

    logic [2:0]      lat_idx = 3'd0;
    logic [7:0]      pv;
    logic [AW-1:0]   pa [8];

    int              checks = 0;
    int              failures = 0;
    int              consumed = 0;
    int              n;
    int              base;
    logic [AW-1:0]   sb [$];

    insn_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stage_out_insn (out)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
        return {a, a[7:0] ^ 8'h5A, a};
    endfunction

    // Memory: response appears lat_idx+1 cycles after the request fires; cleared by rst.
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[6:0], mem_req_valid && mem_req_ready};
        pa[0] <= mem_req_addr;
        for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end

    assign mem_rsp_valid = pv[lat_idx];
    assign mem_rsp_data  = memf(pa[lat_idx]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && out.valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", out.addr);
                end else begin
                    check("out_addr", out.addr, sb[0]);
                    check("out_insn", out.insn, memf(sb[0]));
                    if (!stall) begin
                        void'(sb.pop_front());
                        consumed++;
                    end
                end
            end
        end
    endtask

    task automatic push_seq(input logic [AW-1:0] start, input int cnt);
        logic [AW-1:0] a;
        a = start;
        sb.delete();
        for (int i = 0; i < cnt; i++) begin
            sb.push_back(a);
            a = a + AW'(1);
        end
    endtask

    task automatic wait_consumed(input int target, output int cyc);
        cyc = 0;
        while (consumed < target && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        if (consumed < target) check("timeout_consumed", 64'(consumed), 64'(target));
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 lat_idx = 3'(lat - 1);
        @(negedge clk);
        check("rst_out_valid", 64'(out.valid), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        push_seq(12'h100, 64);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", 64'(mem_req_valid), 64'd1);
        check("first_req_addr", 64'(mem_req_addr), 64'h100);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Latency-1 stream from reset: first output 4 edges after release, then 1/cycle.
        do_reset(1);
        wait_consumed(1, n);
        check("first_out_latency", 64'(n), 64'd4);
        wait_consumed(16, n);
        check("stream_16_cycles", 64'(n), 64'd15);

        // Redirect with stall high while a response lands.
        @(posedge clk);
        #1 stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 12'h050;
        @(posedge clk);
        #1 stall = 1'b0;
        redirect_valid = 1'b0;
        push_seq(12'h050, 64);
        base = consumed;
        @(negedge clk);
        check("redirect_clears_valid", 64'(out.valid), 64'd0);
        wait_consumed(base + 8, n);

        // Redirect to all-ones address wraps to zero.
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_addr = 12'hFFF;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        push_seq(12'hFFF, 64);
        base = consumed;
        wait_consumed(base + 12, n);

        // Memory back-pressure for a few cycles.
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_req_ready = 1'b1;
        base = consumed;
        wait_consumed(base + 10, n);

        // Three stall cycles in steady state: requests stop when credits run out.
        @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("req_continue_stall2", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        check("req_stop_credit_full", 64'(mem_req_valid), 64'd0);
        @(posedge clk);
        #1 stall = 1'b0;
        base = consumed;
        wait_consumed(base + 10, n);

        // Latency 3: redirect with two requests outstanding, both stale responses dropped.
        do_reset(3);
        @(posedge clk);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_addr = 12'h200;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        push_seq(12'h200, 64);
        base = consumed;
        wait_consumed(base + 1, n);
        check("redirect_first_latency", 64'(n), 64'd6);
        wait_consumed(base + 6, n);

        // Reset mid-stream with a filled FIFO; fetch restarts at the start address.
        @(posedge clk);
        #1 stall = 1'b1;
        repeat (8) @(posedge clk);
        do_reset(1);
        base = consumed;
        wait_consumed(base + 1, n);
        check("restart_latency", 64'(n), 64'd4);
        wait_consumed(base + 8, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
